tone_player: RTL and testbench

TONE_PLAYER -- requirements
Module: tone_player

---
 rtl/tone_player.sv | 166 ++++++++++++++++
 tb/tb_tone_player.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_player.sv
// Note sequencer for a piezo buzzer: plays one note or rest per request, then a fixed silent gap.
// All timing advances on rising edges of div_clk_in, which is sampled as data in the sclk domain.
module tone_player #(
   parameter logic [23:0] DUR_UNIT  = 24'd250000,
   parameter logic [7:0]  GAP_UNITS = 8'd1
) (
   input  logic       sclk,
   input  logic       rst_n,
   input  logic       div_clk_in,
   input  logic [2:0] note,
   input  logic [7:0] dur,
   input  logic       note_valid,
   output logic       note_ready,
   input  logic       stop,
   output logic       buzzer_out,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

   state_e      state_q, state_d;
   logic        div_prev_q;
   logic [2:0]  note_q, note_d;
   logic [7:0]  dur_q, dur_d;
   logic [23:0] tick_cnt_q, tick_cnt_d;
   logic [7:0]  unit_cnt_q, unit_cnt_d;
   logic [15:0] tone_cnt_q, tone_cnt_d;
   logic        buzz_q, buzz_d;
   logic        zdone_q, zdone_d;
   logic        exit_done;
   logic        tick;
   logic        unit_end;
   logic [15:0] half_m1;

   assign tick     = div_clk_in & ~div_prev_q;
   assign unit_end = tick && (tick_cnt_q == DUR_UNIT - 24'd1);

   always_comb begin
      half_m1 = '0;
      case (note_q)
         3'd1:    half_m1 = 16'd47778 - 16'd1;
         3'd2:    half_m1 = 16'd42566 - 16'd1;
         3'd3:    half_m1 = 16'd37922 - 16'd1;
         3'd4:    half_m1 = 16'd35793 - 16'd1;
         3'd5:    half_m1 = 16'd31888 - 16'd1;
         3'd6:    half_m1 = 16'd28409 - 16'd1;
         3'd7:    half_m1 = 16'd25310 - 16'd1;
         default: half_m1 = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      note_d     = note_q;
      dur_d      = dur_q;
      tick_cnt_d = tick_cnt_q;
      unit_cnt_d = unit_cnt_q;
      tone_cnt_d = tone_cnt_q;
      buzz_d     = buzz_q;
      zdone_d    = 1'b0;
      exit_done  = 1'b0;

      if (stop) begin
         state_d    = StIdle;
         tick_cnt_d = '0;
         unit_cnt_d = '0;
         tone_cnt_d = '0;
         buzz_d     = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (note_valid) begin
                  note_d     = note;
                  dur_d      = dur;
                  tick_cnt_d = '0;
                  unit_cnt_d = '0;
                  tone_cnt_d = '0;
                  buzz_d     = 1'b0;
                  // A zero-length note completes at once without entering PLAY
                  if (dur == 8'd0) zdone_d = 1'b1;
                  else             state_d = StPlay;
               end
            end
            StPlay: begin
               if (tick) begin
                  if (note_q != 3'd0) begin
                     if (tone_cnt_q == half_m1) begin
                        tone_cnt_d = '0;
                        buzz_d     = ~buzz_q;
                     end else begin
                        tone_cnt_d = tone_cnt_q + 16'd1;
                     end
                  end
                  if (unit_end) begin
                     tick_cnt_d = '0;
                     if (unit_cnt_q == dur_q - 8'd1) begin
                        // Terminal tick: silence the output on the same edge as the exit
                        unit_cnt_d = '0;
                        tone_cnt_d = '0;
                        buzz_d     = 1'b0;
                        if (GAP_UNITS == 8'd0) begin
                           state_d   = StIdle;
                           exit_done = 1'b1;
                        end else begin
                           state_d = StGap;
                        end
                     end else begin
                        unit_cnt_d = unit_cnt_q + 8'd1;
                     end
                  end else begin
                     tick_cnt_d = tick_cnt_q + 24'd1;
                  end
               end
            end
            StGap: begin
               if (tick) begin
                  if (unit_end) begin
                     tick_cnt_d = '0;
                     if (unit_cnt_q == GAP_UNITS - 8'd1) begin
                        unit_cnt_d = '0;
                        state_d    = StIdle;
                        exit_done  = 1'b1;
                     end else begin
                        unit_cnt_d = unit_cnt_q + 8'd1;
                     end
                  end else begin
                     tick_cnt_d = tick_cnt_q + 24'd1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         div_prev_q <= 1'b1;
         note_q     <= '0;
         dur_q      <= '0;
         tick_cnt_q <= '0;
         unit_cnt_q <= '0;
         tone_cnt_q <= '0;
         buzz_q     <= 1'b0;
         zdone_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_prev_q <= div_clk_in;
         note_q     <= note_d;
         dur_q      <= dur_d;
         tick_cnt_q <= tick_cnt_d;
         unit_cnt_q <= unit_cnt_d;
         tone_cnt_q <= tone_cnt_d;
         buzz_q     <= buzz_d;
         zdone_q    <= zdone_d;
      end
   end

   assign note_ready = (state_q == StIdle) && !stop;
   assign busy       = (state_q != StIdle);
   assign done       = exit_done | zdone_q;
   assign buzzer_out = buzz_q;

endmodule

// File: tb/tb_tone_player.sv
// Randomised bench for tone_player: a tick-count reference model predicts every output each cycle.
module tb_tone_player;

   localparam int unsigned UNIT = 100;
   localparam int unsigned GAPU = 1;
   localparam int unsigned HALF [8] = '{1, 47778, 42566, 37922, 35793, 31888, 28409, 25310};

   logic       sclk = 1'b0;
   logic       rst_n;
   logic       div_clk_in;
   logic [2:0] note;
   logic [7:0] dur;
   logic       note_valid;
   logic       note_ready;
   logic       stop;
   logic       buzzer_out;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   always #5 sclk = ~sclk;

   tone_player #(
      .DUR_UNIT  (24'd100),
      .GAP_UNITS (8'd1)
   ) dut (
      .sclk       (sclk),
      .rst_n      (rst_n),
      .div_clk_in (div_clk_in),
      .note       (note),
      .dur        (dur),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .stop       (stop),
      .buzzer_out (buzzer_out),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Upstream divider model: period div_mode sclk cycles, or held high
   int unsigned div_mode = 4;
   bit          div_hold = 1'b0;
   int unsigned div_ph   = 0;
   initial begin
      div_clk_in = 1'b0;
      forever begin
         @(posedge sclk);
         #1;
         if (div_hold) begin
            div_clk_in = 1'b1;
         end else begin
            div_ph     = (div_ph + 1) % div_mode;
            div_clk_in = (div_ph >= div_mode / 2);
         end
      end
   end

   // Reference model: a note is just a count of elapsed ticks against dur and gap lengths
   logic        m_active, m_zdone, m_prev;
   logic [2:0]  m_note;
   int unsigned m_t, m_play, m_total;
   logic        m_tick, exp_busy, exp_ready, exp_done, exp_buzz;

   always @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_zdone  <= 1'b0;
         m_prev   <= 1'b1;
         m_t      <= 0;
         m_note   <= '0;
         m_play   <= 0;
         m_total  <= 0;
      end else begin
         m_prev  <= div_clk_in;
         m_zdone <= 1'b0;
         if (stop) begin
            m_active <= 1'b0;
         end else if (!m_active) begin
            if (note_valid) begin
               if (dur == 8'd0) begin
                  m_zdone <= 1'b1;
               end else begin
                  m_active <= 1'b1;
                  m_t      <= 0;
                  m_note   <= note;
                  m_play   <= 32'(dur) * UNIT;
                  m_total  <= (32'(dur) + GAPU) * UNIT;
               end
            end
         end else if (m_tick) begin
            m_t <= m_t + 1;
            if (m_t + 1 == m_total) m_active <= 1'b0;
         end
      end
   end

   always_comb begin
      m_tick    = div_clk_in & ~m_prev;
      exp_busy  = m_active;
      exp_ready = !m_active && !stop;
      exp_done  = m_zdone || (m_active && m_tick && !stop && (m_t + 1 == m_total));
      exp_buzz  = m_active && (m_note != 3'd0) && (m_t < m_play) &&
                  (((m_t / HALF[m_note]) % 2) == 1);
   end

   int cyc = 0, n_done = 0, n_exp_done = 0, n_acc = 0, n_busy_ticks = 0, n_buzz_hi = 0;
   int rise_ticks = -1, done_cyc = 0, acc_cyc = 0, ticks_at_done = 0;
   int mm_busy = 0, mm_ready = 0, mm_done = 0, mm_buzz = 0;
   bit buzz_prev = 1'b0;

   always @(negedge sclk) begin
      if (busy !== exp_busy)        mm_busy  <= mm_busy + 1;
      if (note_ready !== exp_ready) mm_ready <= mm_ready + 1;
      if (done !== exp_done)        mm_done  <= mm_done + 1;
      if (buzzer_out !== exp_buzz)  mm_buzz  <= mm_buzz + 1;
      if (exp_done) n_exp_done <= n_exp_done + 1;
      if (note_valid === 1'b1 && note_ready === 1'b1) begin
         n_acc   <= n_acc + 1;
         acc_cyc <= cyc;
      end
      if (buzzer_out === 1'b1 && !buzz_prev) rise_ticks <= n_busy_ticks;
      buzz_prev <= (buzzer_out === 1'b1);
      if (buzzer_out === 1'b1) n_buzz_hi <= n_buzz_hi + 1;
      if (busy === 1'b1 && m_tick) n_busy_ticks <= n_busy_ticks + 1;
      if (done === 1'b1) begin
         n_done        <= n_done + 1;
         done_cyc      <= cyc;
         ticks_at_done <= n_busy_ticks + ((busy === 1'b1 && m_tick) ? 1 : 0);
      end
      cyc <= cyc + 1;
   end

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   task automatic send(input logic [2:0] n, input logic [7:0] d);
      for (int i = 0; i < 5000; i++) begin
         if (note_ready === 1'b1) break;
         step();
      end
      note       = n;
      dur        = d;
      note_valid = 1'b1;
      step();
      note_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (busy === 1'b0) break;
         step();
      end
      check(tag, busy, 0);
   endtask

   int b_done, b_ticks, b_hi, b_exp;

   task automatic snap();
      b_done  = n_done;
      b_ticks = n_busy_ticks;
      b_hi    = n_buzz_hi;
      b_exp   = n_exp_done;
   endtask

   initial begin
      rst_n      = 1'b1;
      stop       = 1'b0;
      note_valid = 1'b0;
      note       = '0;
      dur        = '0;
      #1 rst_n = 1'b0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_buzz", buzzer_out, 0);
      check("rst_ready", note_ready, 1);
      rst_n = 1'b1;
      repeat (4) step();

      // B4 for two units: far shorter than a half-period, so silent
      snap();
      send(3'd7, 8'd2);
      wait_idle("b4_idle", 3000);
      repeat (3) step();
      check("b4_done", n_done - b_done, 1);
      check("b4_busy_ticks", n_busy_ticks - b_ticks, 300);
      check("b4_buzz_hi", n_buzz_hi - b_hi, 0);

      // Rest for three units
      snap();
      send(3'd0, 8'd3);
      wait_idle("rest_idle", 3000);
      repeat (3) step();
      check("rest_done", n_done - b_done, 1);
      check("rest_busy_ticks", n_busy_ticks - b_ticks, 400);
      check("rest_buzz_hi", n_buzz_hi - b_hi, 0);

      // Zero duration
      send(3'd5, 8'd0);
      @(negedge sclk);
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      step();
      @(negedge sclk);
      check("zero_done_end", done, 0);
      check("zero_ready", note_ready, 1);
      step();

      // Stop mid-PLAY, then stop together with a request in IDLE
      snap();
      send(3'd6, 8'd3);
      repeat (60) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      @(negedge sclk);
      check("stop_busy", busy, 0);
      check("stop_buzz", buzzer_out, 0);
      step();
      note = 3'd1; dur = 8'd5; note_valid = 1'b1; stop = 1'b1;
      @(negedge sclk);
      check("stop_ready", note_ready, 0);
      step();
      note_valid = 1'b0; stop = 1'b0;
      repeat (10) step();
      check("stop_req_busy", busy, 0);
      check("stop_no_done", n_done - b_done, 0);

      // Reset mid-PLAY with div_clk_in held high
      snap();
      send(3'd3, 8'd2);
      repeat (100) step();
      div_hold = 1'b1;
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_buzz", buzzer_out, 0);
      check("arst_done", done, 0);
      check("arst_ready", note_ready, 1);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (5) step();
      div_hold = 1'b0;
      repeat (20) step();
      check("arst_no_done", n_done - b_done, 0);
      check("arst_idle", busy, 0);

      // Second request held during PLAY waits for note_ready, then follows the gap
      snap();
      send(3'd2, 8'd1);
      note = 3'd4; dur = 8'd1; note_valid = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (n_acc - b_done >= 0 && acc_cyc > done_cyc && n_done > b_done) break;
         step();
      end
      note_valid = 1'b0;
      check("b2b_first_ticks", ticks_at_done - b_ticks, 200);
      check("b2b_accept_cycle", acc_cyc - done_cyc, 1);
      wait_idle("b2b_idle", 3000);
      repeat (3) step();
      check("b2b_done", n_done - b_done, 2);
      check("b2b_busy_ticks", n_busy_ticks - b_ticks, 400);

      // Random notes with occasional aborts
      snap();
      for (int k = 0; k < 12; k++) begin
         send(3'($urandom_range(0, 7)), 8'($urandom_range(0, 2)));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 300)) step();
            stop = 1'b1;
            step();
            stop = 1'b0;
         end else begin
            wait_idle("rand_idle", 3000);
         end
         repeat (2) step();
      end
      check("rand_done", n_done - b_done, n_exp_done - b_exp);

      // Long B4 on a faster divider so the first toggle is reached
      div_mode = 2;
      snap();
      send(3'd7, 8'd255);
      wait_idle("long_idle", 60000);
      repeat (3) step();
      check("long_rise_ticks", rise_ticks - b_ticks, 25310);
      check("long_done", n_done - b_done, 1);
      check("long_busy_ticks", n_busy_ticks - b_ticks, 25600);
      check("long_buzz_end", buzzer_out, 0);

      check("trace_busy", mm_busy, 0);
      check("trace_ready", mm_ready, 0);
      check("trace_done", mm_done, 0);
      check("trace_buzz", mm_buzz, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #980000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule
